// File: rtl/ifetch_queue_if.sv
// ifetch_queue_if: signals between the instruction fetch front end, the instruction RAM read
// port and the decode stage.
//   master : fetch unit side (drives mem_addr and the inst_* outputs)
//   slave  : environment side (RAM data, redirect request, decode ready)
// Signals:
//   mem_addr       byte address to the RAM read port (registered in the RAM)
//   mem_dout       RAM read data, valid the cycle after mem_addr
//   redirect_valid one-cycle pulse restarting fetch at redirect_pc
//   redirect_pc    new fetch address (low two bits ignored)
//   inst_valid     head instruction valid
//   inst_ready     decode accepts the head this cycle
//   inst, inst_pc  head instruction word and its byte address
interface ifetch_queue_if #(
  parameter int unsigned ADDR_WIDTH = 16,
  parameter int unsigned DATA_WIDTH = 32
) ();

  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0] mem_dout;
  logic                  redirect_valid;
  logic [ADDR_WIDTH-1:0] redirect_pc;
  logic                  inst_valid;
  logic                  inst_ready;
  logic [DATA_WIDTH-1:0] inst;
  logic [ADDR_WIDTH-1:0] inst_pc;

  modport master (
    output mem_addr,
    input  mem_dout,
    input  redirect_valid,
    input  redirect_pc,
    output inst_valid,
    input  inst_ready,
    output inst,
    output inst_pc
  );

  modport slave (
    input  mem_addr,
    output mem_dout,
    output redirect_valid,
    output redirect_pc,
    input  inst_valid,
    output inst_ready,
    input  inst,
    input  inst_pc
  );

endinterface

// File: rtl/ifetch_queue.sv
// ifetch_queue: instruction fetch front end. Issues sequential word fetches to the instruction
// RAM, captures the word returned one cycle later into a small prefetch FIFO and presents the
// FIFO head to decode with a valid/ready handshake. A redirect flushes the FIFO, drops any
// response in flight and restarts fetch at the (word-aligned) redirect address.
// Ports:
//   clk  rising-edge clock
//   rst  synchronous active-high reset
//   bus  ifetch_queue_if.master: RAM address/data, redirect, decode handshake
// Optional feature, macro IFETCH_BYPASS_EN: when the FIFO is empty the arriving RAM word is
// presented to decode in the same cycle and is only queued if decode does not take it.
module ifetch_queue #(
  parameter int unsigned           ADDR_WIDTH = 16,
  parameter int unsigned           DATA_WIDTH = 32,
  parameter int unsigned           DEPTH_LOG2 = 2,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0
) (
  input logic            clk,
  input logic            rst,
  ifetch_queue_if.master bus
);

  localparam int unsigned Depth = 1 << DEPTH_LOG2;
  localparam int unsigned CntW  = DEPTH_LOG2 + 1;
  localparam int unsigned OccW  = DEPTH_LOG2 + 2;

  logic [ADDR_WIDTH-1:0] fetch_pc_q, fetch_pc_d;
  logic                  req_q, req_d;
  logic [ADDR_WIDTH-1:0] req_pc_q, req_pc_d;
  logic [CntW-1:0]       count_q, count_d;
  logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
  logic [DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d;

  logic [DATA_WIDTH-1:0] inst_mem [Depth];
  logic [ADDR_WIDTH-1:0] pc_mem   [Depth];

  logic            head_valid;
  logic            bypass;
  logic            valid;
  logic            pop;
  logic            fifo_pop;
  logic            push;
  logic            issue;
  logic [OccW-1:0] occupancy;

  // Low address bits of a redirect are ignored (word-aligned fetch only).
  logic unused_redirect_lsbs;
  assign unused_redirect_lsbs = ^bus.redirect_pc[1:0];

  assign head_valid = (count_q != '0);

`ifdef IFETCH_BYPASS_EN
  assign bypass = req_q && !head_valid;
`else
  assign bypass = 1'b0;
`endif

  assign valid    = head_valid || bypass;
  assign pop      = valid && bus.inst_ready;
  assign fifo_pop = pop && head_valid;
  // A bypassed word taken by decode in its arrival cycle is never queued.
  assign push     = req_q && !(bypass && bus.inst_ready);

  // Credit check: queued words plus the one in flight, less the one leaving, must leave room.
  assign occupancy = OccW'(count_q) + OccW'(req_q) - OccW'(pop);
  assign issue     = !bus.redirect_valid && (occupancy < OccW'(Depth));

  always_comb begin
    fetch_pc_d = fetch_pc_q;
    req_d      = 1'b0;
    req_pc_d   = req_pc_q;
    count_d    = count_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    if (bus.redirect_valid) begin
      // Flush; clearing req_d drops the response that arrives next cycle.
      fetch_pc_d = {bus.redirect_pc[ADDR_WIDTH-1:2], 2'b00};
      count_d    = '0;
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
    end else begin
      if (issue) begin
        fetch_pc_d = fetch_pc_q + ADDR_WIDTH'(4);
        req_d      = 1'b1;
        req_pc_d   = fetch_pc_q;
      end
      if (push) begin
        wr_ptr_d = wr_ptr_q + DEPTH_LOG2'(1);
      end
      if (fifo_pop) begin
        rd_ptr_d = rd_ptr_q + DEPTH_LOG2'(1);
      end
      count_d = count_q + CntW'(push) - CntW'(fifo_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc_q <= RESET_PC;
      req_q      <= 1'b0;
      req_pc_q   <= '0;
      count_q    <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      req_q      <= req_d;
      req_pc_q   <= req_pc_d;
      count_q    <= count_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
    end
  end

  // Storage needs no reset: entries are only visible while count_q covers them.
  always_ff @(posedge clk) begin
    if (push) begin
      inst_mem[wr_ptr_q] <= bus.mem_dout;
      pc_mem[wr_ptr_q]   <= req_pc_q;
    end
  end

  assign bus.mem_addr = fetch_pc_q;

  always_comb begin
    bus.inst_valid = valid;
    bus.inst       = '0;
    bus.inst_pc    = '0;
    if (head_valid) begin
      bus.inst    = inst_mem[rd_ptr_q];
      bus.inst_pc = pc_mem[rd_ptr_q];
    end else if (bypass) begin
      bus.inst    = bus.mem_dout;
      bus.inst_pc = req_pc_q;
    end
  end

endmodule

// File: tb/tb_ifetch_queue.sv
// Testbench for ifetch_queue (default build). A registered RAM model answers fetches; a
// table of per-cycle {inputs, expected outputs} rows covers reset, streaming, backpressure,
// redirects and mid-stream reset, followed by hand-written wrap-around and redirect-latency
// sequences.
module tb_ifetch_queue;

  localparam int unsigned AW = 16;
  localparam int unsigned DW = 32;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  ifetch_queue_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();
  ifetch_queue_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus2 ();

  ifetch_queue #(
    .ADDR_WIDTH(AW),
    .DATA_WIDTH(DW),
    .DEPTH_LOG2(2),
    .RESET_PC  (16'h0000)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  ifetch_queue #(
    .ADDR_WIDTH(AW),
    .DATA_WIDTH(DW),
    .DEPTH_LOG2(2),
    .RESET_PC  (16'hFFF8)
  ) dut2 (
    .clk(clk),
    .rst(rst),
    .bus(bus2)
  );

  function automatic logic [31:0] ram_word(input logic [15:0] a);
    case (a)
      16'h0000: ram_word = 32'h00000013;
      16'h0004: ram_word = 32'h00100093;
      16'h0008: ram_word = 32'h00200113;
      default:  ram_word = {a ^ 16'h5A5A, a};
    endcase
  endfunction

  // Registered read port: data appears the cycle after the address.
  always @(posedge clk) begin
    bus.mem_dout  <= ram_word(bus.mem_addr);
    bus2.mem_dout <= ram_word(bus2.mem_addr);
  end

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %08h expected %08h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        rst;
    logic        rv;
    logic [15:0] rpc;
    logic        rdy;
    logic        ev;
    logic [15:0] epc;
    logic [15:0] eaddr;
  } vec_t;

  function automatic vec_t mk(input logic r, input logic rv, input logic [15:0] rpc,
                              input logic rdy, input logic ev, input logic [15:0] epc,
                              input logic [15:0] eaddr);
    vec_t v;
    v.rst = r; v.rv = rv; v.rpc = rpc; v.rdy = rdy; v.ev = ev; v.epc = epc; v.eaddr = eaddr;
    return v;
  endfunction

  localparam int NVec = 42;
  vec_t tbl [NVec];

  // Wrap-around stream of the RESET_PC=0xFFF8 instance after reset.
  logic        w_ev    [6] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
  logic [15:0] w_pc    [6] = '{16'h0000, 16'h0000, 16'hFFF8, 16'hFFFC, 16'h0000, 16'h0004};
  logic [15:0] w_addr  [6] = '{16'hFFF8, 16'hFFFC, 16'h0000, 16'h0004, 16'h0008, 16'h000C};

  initial begin
    int n;
    logic [31:0] exp_inst;

    // Row: outputs expected during the cycle, inputs applied at the closing edge.
    //             rst rv  rpc       rdy ev  epc       eaddr
    tbl[0]  = mk(1, 0, 16'h0000, 1, 0, 16'h0000, 16'h0000);
    tbl[1]  = mk(1, 0, 16'h0000, 1, 0, 16'h0000, 16'h0000);
    tbl[2]  = mk(0, 0, 16'h0000, 1, 0, 16'h0000, 16'h0000);
    tbl[3]  = mk(0, 0, 16'h0000, 1, 0, 16'h0000, 16'h0004);
    tbl[4]  = mk(0, 0, 16'h0000, 1, 1, 16'h0000, 16'h0008);
    tbl[5]  = mk(0, 0, 16'h0000, 1, 1, 16'h0004, 16'h000C);
    tbl[6]  = mk(0, 0, 16'h0000, 1, 1, 16'h0008, 16'h0010);
    tbl[7]  = mk(1, 0, 16'h0000, 1, 1, 16'h000C, 16'h0014);
    // Backpressure: ten cycles of inst_ready=0, fetch stalls at 0x0010.
    tbl[8]  = mk(0, 0, 16'h0000, 0, 0, 16'h0000, 16'h0000);
    tbl[9]  = mk(0, 0, 16'h0000, 0, 0, 16'h0000, 16'h0004);
    tbl[10] = mk(0, 0, 16'h0000, 0, 1, 16'h0000, 16'h0008);
    tbl[11] = mk(0, 0, 16'h0000, 0, 1, 16'h0000, 16'h000C);
    for (int i = 12; i < 18; i++) tbl[i] = mk(0, 0, 16'h0000, 0, 1, 16'h0000, 16'h0010);
    tbl[18] = mk(0, 0, 16'h0000, 1, 1, 16'h0000, 16'h0010);
    tbl[19] = mk(0, 0, 16'h0000, 1, 1, 16'h0004, 16'h0014);
    tbl[20] = mk(0, 0, 16'h0000, 1, 1, 16'h0008, 16'h0018);
    tbl[21] = mk(0, 0, 16'h0000, 1, 1, 16'h000C, 16'h001C);
    tbl[22] = mk(0, 0, 16'h0000, 1, 1, 16'h0010, 16'h0020);
    tbl[23] = mk(0, 0, 16'h0000, 1, 1, 16'h0014, 16'h0024);
    tbl[24] = mk(1, 0, 16'h0000, 1, 1, 16'h0018, 16'h0028);
    // Redirect with 3 queued + 1 in flight (pop in the same cycle is void).
    tbl[25] = mk(0, 0, 16'h0000, 0, 0, 16'h0000, 16'h0000);
    tbl[26] = mk(0, 0, 16'h0000, 0, 0, 16'h0000, 16'h0004);
    tbl[27] = mk(0, 0, 16'h0000, 0, 1, 16'h0000, 16'h0008);
    tbl[28] = mk(0, 0, 16'h0000, 0, 1, 16'h0000, 16'h000C);
    tbl[29] = mk(0, 1, 16'h0040, 1, 1, 16'h0000, 16'h0010);
    tbl[30] = mk(0, 0, 16'h0000, 1, 0, 16'h0000, 16'h0040);
    tbl[31] = mk(0, 0, 16'h0000, 1, 0, 16'h0000, 16'h0044);
    tbl[32] = mk(0, 0, 16'h0000, 1, 1, 16'h0040, 16'h0048);
    // Misaligned redirect restarts at 0x0040.
    tbl[33] = mk(0, 1, 16'h0043, 1, 1, 16'h0044, 16'h004C);
    tbl[34] = mk(0, 0, 16'h0000, 1, 0, 16'h0000, 16'h0040);
    tbl[35] = mk(0, 0, 16'h0000, 1, 0, 16'h0000, 16'h0044);
    tbl[36] = mk(0, 0, 16'h0000, 0, 1, 16'h0040, 16'h0048);
    // Reset with two words queued.
    tbl[37] = mk(1, 0, 16'h0000, 1, 1, 16'h0040, 16'h004C);
    tbl[38] = mk(0, 0, 16'h0000, 1, 0, 16'h0000, 16'h0000);
    tbl[39] = mk(0, 0, 16'h0000, 1, 0, 16'h0000, 16'h0004);
    tbl[40] = mk(0, 0, 16'h0000, 1, 1, 16'h0000, 16'h0008);
    tbl[41] = mk(0, 0, 16'h0000, 1, 1, 16'h0004, 16'h000C);

    bus.redirect_valid  = 1'b0;
    bus.redirect_pc     = '0;
    bus.inst_ready      = 1'b1;
    bus2.redirect_valid = 1'b0;
    bus2.redirect_pc    = '0;
    bus2.inst_ready     = 1'b1;
    rst = 1'b1;
    @(posedge clk);
    #1;

    for (int i = 0; i < NVec; i++) begin
      rst                = tbl[i].rst;
      bus.redirect_valid = tbl[i].rv;
      bus.redirect_pc    = tbl[i].rpc;
      bus.inst_ready     = tbl[i].rdy;
      @(negedge clk);
      exp_inst = tbl[i].ev ? ram_word(tbl[i].epc) : 32'h0;
      check($sformatf("row%0d inst_valid", i), 32'(bus.inst_valid), 32'(tbl[i].ev));
      check($sformatf("row%0d inst_pc", i), 32'(bus.inst_pc), 32'(tbl[i].epc));
      check($sformatf("row%0d inst", i), bus.inst, exp_inst);
      check($sformatf("row%0d mem_addr", i), 32'(bus.mem_addr), 32'(tbl[i].eaddr));
      @(posedge clk);
      #1;
    end
    rst                = 1'b0;
    bus.redirect_valid = 1'b0;
    bus.inst_ready     = 1'b1;

    // Wrap-around on the RESET_PC=0xFFF8 instance.
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      exp_inst = w_ev[k] ? ram_word(w_pc[k]) : 32'h0;
      check($sformatf("wrap%0d inst_valid", k), 32'(bus2.inst_valid), 32'(w_ev[k]));
      check($sformatf("wrap%0d inst_pc", k), 32'(bus2.inst_pc), 32'(w_pc[k]));
      check($sformatf("wrap%0d inst", k), bus2.inst, exp_inst);
      check($sformatf("wrap%0d mem_addr", k), 32'(bus2.mem_addr), 32'(w_addr[k]));
      @(posedge clk);
      #1;
    end

    // Redirect-to-valid latency while streaming: valid on the third cycle after the redirect.
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 16'h0080;
    @(posedge clk);
    #1;
    bus.redirect_valid = 1'b0;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!bus.inst_valid && n < 10);
    if (!bus.inst_valid) begin
      errors++;
      checks++;
      $display("FAIL redirect wait: inst_valid never rose within %0d cycles", n);
    end else begin
      check("redirect latency", 32'(n), 32'd3);
      check("redirect first pc", 32'(bus.inst_pc), 32'h0080);
      check("redirect first inst", bus.inst, ram_word(16'h0080));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
